// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle (aw, w, b, ar, r channels) with master and slave views.
interface axi4_lite_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_mem_wrapper.sv
// AXI4-Lite slave word memory with independent AW/W buffering, byte strobes and
// a base-offset subtracted from every address.
// Optional feature macro: AXIL_MEM_WRAPPER_RANGE_CHECK_EN
//   defined   : out-of-window accesses answer SLVERR, writes dropped, reads return 0
//   undefined : word index wraps modulo DEPTH, responses always OKAY
module axil_mem_wrapper #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          aclk,
    input  logic          aresetn,
    axi4_lite_if.slave    axi,
    input  logic [AW-1:0] offset
);
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned SHIFT = $clog2(SW);
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [DW-1:0] mem_q [DEPTH];

    logic          aw_full_q, aw_full_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic          w_full_q, w_full_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          arready_q, arready_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          wr_err, rd_err;

    // Protection bits carry no meaning for this memory
    logic unused_prot;
    assign unused_prot = ^{axi.awprot, axi.arprot};

    function automatic logic [AW-1:0] word_of(input logic [AW-1:0] addr,
                                              input logic [AW-1:0] base);
        return (addr - base) >> SHIFT;
    endfunction

`ifdef AXIL_MEM_WRAPPER_RANGE_CHECK_EN
    function automatic logic addr_err(input logic [AW-1:0] addr,
                                      input logic [AW-1:0] base);
        return (addr < base) || (word_of(addr, base) >= AW'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [AW-1:0] addr,
                                             input logic [AW-1:0] base);
        return IW'(word_of(addr, base));
    endfunction
`else
    function automatic logic [IW-1:0] idx_of(input logic [AW-1:0] addr,
                                             input logic [AW-1:0] base);
        return IW'(word_of(addr, base) % AW'(DEPTH));
    endfunction
`endif

    // Handshake decode and selection of the committing write (buffer or live bus)
    always_comb begin
        aw_hs   = axi.awvalid & awready_q;
        w_hs    = axi.wvalid & wready_q;
        ar_hs   = axi.arvalid & arready_q;
        commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
        wr_addr = aw_full_q ? aw_addr_q : axi.awaddr;
        wr_data = w_full_q ? w_data_q : axi.wdata;
        wr_strb = w_full_q ? w_strb_q : axi.wstrb;
        wr_idx  = idx_of(wr_addr, offset);
        rd_idx  = idx_of(axi.araddr, offset);
`ifdef AXIL_MEM_WRAPPER_RANGE_CHECK_EN
        wr_err  = addr_err(wr_addr, offset);
        rd_err  = addr_err(axi.araddr, offset);
`else
        wr_err  = 1'b0;
        rd_err  = 1'b0;
`endif
    end

    // Next state for buffers, responses and registered readies
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi.awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi.wdata;
            w_strb_d = axi.wstrb;
        end
        if (bvalid_q && axi.bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
        end

        if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? '0 : mem_q[rd_idx];
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end

        // One outstanding write and one outstanding read at a time
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    // Control and response registers; reset discards any pending transaction
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

    // Byte-lane write on commit; the array itself is intentionally not reset
    always_ff @(posedge aclk) begin
        if (commit && !wr_err) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axil_mem_wrapper.sv
// Self-checking bench for axil_mem_wrapper: directed table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_axil_mem_wrapper;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] offset = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];

    axi4_lite_if #(.AW(32), .DW(32)) axi_if ();

    axil_mem_wrapper #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .axi     (axi_if.slave),
        .offset  (offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_hold;
        int          r_hold;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference address rules: byte offset from base, word index, optional window check
    function automatic bit m_err(input logic [31:0] a);
        logic [31:0] diff;
        diff = a - offset;
`ifdef AXIL_MEM_WRAPPER_RANGE_CHECK_EN
        return (a < offset) || ((diff / 4) >= DEPTH);
`else
        return (diff == diff) ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] diff;
        diff = a - offset;
        return int'((diff / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] a);
        return m_err(a) ? 32'h0 : model_mem[m_idx(a)];
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_err(a) ? 2'b10 : 2'b00;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!m_err(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // Write with independent AW/W start cycles and B backpressure; runs on negedges
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_hold, input string nm);
        bit aw_done, w_done, aw_hs, w_hs, early_b;
        int k;
        logic [1:0] exp_resp;
        aw_done = 1'b0; w_done = 1'b0; early_b = 1'b0; k = 0;
        axi_if.bready = 1'b0;
        while (!(aw_done && w_done) && k < 64) begin
            if (k == aw_dly) begin axi_if.awvalid = 1'b1; axi_if.awaddr = a; end
            if (k == w_dly) begin axi_if.wvalid = 1'b1; axi_if.wdata = d; axi_if.wstrb = s; end
            aw_hs = axi_if.awvalid && axi_if.awready;
            w_hs  = axi_if.wvalid && axi_if.wready;
            @(negedge clk);
            k++;
            if (aw_hs) begin axi_if.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin axi_if.wvalid = 1'b0;  w_done = 1'b1;  end
            if (!(aw_done && w_done) && axi_if.bvalid) early_b = 1'b1;
        end
        axi_if.awvalid = 1'b0;
        axi_if.wvalid  = 1'b0;
        chk({nm, "/wr_accept"}, 32'(aw_done && w_done), 32'd1);
        chk({nm, "/early_b"}, 32'(early_b), 32'd0);
        exp_resp = m_resp(a);
        m_write(a, d, s);
        chk({nm, "/b_state"}, {29'd0, axi_if.bvalid, axi_if.awready, axi_if.wready}, 32'b100);
        chk({nm, "/bresp"}, 32'(axi_if.bresp), 32'(exp_resp));
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clk);
            chk({nm, "/b_held"}, {29'd0, axi_if.bvalid, axi_if.awready, axi_if.wready}, 32'b100);
        end
        axi_if.bready = 1'b1;
        @(negedge clk);
        axi_if.bready = 1'b0;
        chk({nm, "/b_done"}, {29'd0, axi_if.bvalid, axi_if.awready, axi_if.wready}, 32'b011);
    endtask

    // Read with R backpressure; expected data and response supplied by caller
    task automatic axi_read(input logic [31:0] a, input int r_hold, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string nm);
        bit hs;
        int k;
        hs = 1'b0; k = 0;
        axi_if.rready  = 1'b0;
        axi_if.arvalid = 1'b1;
        axi_if.araddr  = a;
        while (!hs && k < 64) begin
            hs = axi_if.arvalid && axi_if.arready;
            @(negedge clk);
            k++;
        end
        axi_if.arvalid = 1'b0;
        chk({nm, "/rd_accept"}, 32'(hs), 32'd1);
        chk({nm, "/r_state"}, {30'd0, axi_if.rvalid, axi_if.arready}, 32'b10);
        chk({nm, "/rdata"}, axi_if.rdata, exp_data);
        chk({nm, "/rresp"}, 32'(axi_if.rresp), 32'(exp_resp));
        for (int i = 0; i < r_hold; i++) begin
            @(negedge clk);
            chk({nm, "/r_held"}, {30'd0, axi_if.rvalid, axi_if.arready}, 32'b10);
            chk({nm, "/rdata_held"}, axi_if.rdata, exp_data);
        end
        axi_if.rready = 1'b1;
        @(negedge clk);
        axi_if.rready = 1'b0;
        chk({nm, "/r_done"}, {30'd0, axi_if.rvalid, axi_if.arready}, 32'b01);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        logic [31:0] old_word, new_word, ra, rd;
        logic [3:0]  rs;

        axi_if.awvalid = 1'b0; axi_if.awaddr = '0; axi_if.awprot = '0;
        axi_if.wvalid  = 1'b0; axi_if.wdata  = '0; axi_if.wstrb  = '0;
        axi_if.bready  = 1'b0;
        axi_if.arvalid = 1'b0; axi_if.araddr = '0; axi_if.arprot = '0;
        axi_if.rready  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

        //           addr      data           strb    awd wd bh rh  expected readback
        vt[0] = '{32'h10, 32'h12345678, 4'hF, 0, 0, 0, 0, 32'h12345678};
        vt[1] = '{32'h04, 32'hAABBCCDD, 4'hF, 2, 0, 0, 0, 32'hAABBCCDD};
        vt[2] = '{32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 32'hFFFFFFFF};
        vt[3] = '{32'h08, 32'h00000000, 4'h2, 0, 0, 0, 0, 32'hFFFF00FF};
        vt[4] = '{32'h0C, 32'h11223344, 4'hF, 0, 0, 5, 5, 32'h11223344};
        vt[5] = '{32'h0C, 32'hA5A5A5A5, 4'h9, 1, 0, 1, 2, 32'hA52233A5};

        // Reset state, then readies one cycle after release
        repeat (3) @(negedge clk);
        chk("rst/flags", {27'd0, axi_if.awready, axi_if.wready, axi_if.arready,
                          axi_if.bvalid, axi_if.rvalid}, 32'b00000);
        chk("rst/rdata", axi_if.rdata, 32'h0);
        chk("rst/resp", {28'd0, axi_if.bresp, axi_if.rresp}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel/flags", {27'd0, axi_if.awready, axi_if.wready, axi_if.arready,
                          axi_if.bvalid, axi_if.rvalid}, 32'b11100);

        for (int i = 0; i < 6; i++) begin
            axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly, vt[i].w_dly,
                      vt[i].b_hold, $sformatf("tbl%0d", i));
            axi_read(vt[i].addr, vt[i].r_hold, vt[i].exp_rdata, 2'b00, $sformatf("tbl%0d", i));
        end

        // Fill the random working set so every later read has a known value
        for (int i = 0; i < 16; i++) begin
            axi_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0, "fill");
        end

        // Same-cycle write commit and read of one word: read sees the old value
        old_word = model_mem[8];
        new_word = ~old_word;
        chk("raw/ready", {29'd0, axi_if.awready, axi_if.wready, axi_if.arready}, 32'b111);
        axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h20;
        axi_if.wvalid  = 1'b1; axi_if.wdata  = new_word; axi_if.wstrb = 4'hF;
        axi_if.arvalid = 1'b1; axi_if.araddr = 32'h20;
        @(negedge clk);
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0; axi_if.arvalid = 1'b0;
        chk("raw/valids", {30'd0, axi_if.bvalid, axi_if.rvalid}, 32'b11);
        chk("raw/old_data", axi_if.rdata, old_word);
        model_mem[8] = new_word;
        axi_if.bready = 1'b1; axi_if.rready = 1'b1;
        @(negedge clk);
        axi_if.bready = 1'b0; axi_if.rready = 1'b0;
        axi_read(32'h20, 0, new_word, 2'b00, "raw/new");

        // Base offset relocation and the address-window boundaries
        offset = 32'h1000;
        axi_write(32'h1004, 32'h5, 4'hF, 0, 0, 0, "off");
        axi_read(32'h1004, 0, 32'h5, 2'b00, "off");
        axi_write(32'h0FFC, 32'h77, 4'hF, 0, 0, 0, "below");
        axi_read(32'h0FFC, 0, m_data(32'h0FFC), m_resp(32'h0FFC), "below");
        axi_write(32'h2000, 32'h99, 4'hF, 1, 0, 0, "above");
        axi_read(32'h2000, 1, m_data(32'h2000), m_resp(32'h2000), "above");
`ifndef AXIL_MEM_WRAPPER_RANGE_CHECK_EN
        offset = 32'h0;
        axi_read(32'hFFC, 0, 32'h77, 2'b00, "wrap_last");
`endif
        offset = 32'h0;
        axi_read(32'h4, 0, m_data(32'h4), 2'b00, "off_chk");

        // Reset with only a write address buffered: nothing must survive
        chk("mid/awready", 32'(axi_if.awready), 32'd1);
        axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h10;
        @(negedge clk);
        axi_if.awvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid/in_rst", {27'd0, axi_if.awready, axi_if.wready, axi_if.arready,
                           axi_if.bvalid, axi_if.rvalid}, 32'b00000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid/rel", {27'd0, axi_if.awready, axi_if.wready, axi_if.arready,
                        axi_if.bvalid, axi_if.rvalid}, 32'b11100);
        axi_read(32'h10, 0, m_data(32'h10), 2'b00, "mid/unchanged");
        axi_write(32'h14, 32'hCAFEF00D, 4'hF, 3, 0, 0, "mid/w_first");
        axi_read(32'h10, 0, m_data(32'h10), 2'b00, "mid/still");
        axi_read(32'h14, 0, 32'hCAFEF00D, 2'b00, "mid/new");

        // Randomized mixed traffic over the filled working set
        for (int n = 0; n < 150; n++) begin
            ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                axi_write(ra, rd, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), "rnd_wr");
            end else begin
                axi_read(ra, int'($urandom_range(0, 2)), m_data(ra), m_resp(ra), "rnd_rd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
